// File: rtl/control_carga_instrucciones_if.sv
// Bundle between the instruction loader and its environment: byte stream in, memory write port
// out, plus the CPU run/step/halt control and status lines.
interface control_carga_instrucciones_if #(
  parameter int unsigned NBITS = 32
) ();
  logic             i_start_load;
  logic [7:0]       i_byte;
  logic             i_byte_valid;
  logic             o_byte_ready;
  logic             i_run;
  logic             i_step;
  logic             i_halt;
  logic             o_mem_sel;
  logic             o_mem_we;
  logic [NBITS-1:0] o_mem_addr;
  logic [NBITS-1:0] o_mem_data;
  logic             o_cpu_enable;
  logic             o_load_done;
  logic             o_error;
  logic [2:0]       o_state;

  // Loader side.
  modport master (
    input  i_start_load, i_byte, i_byte_valid, i_run, i_step, i_halt,
    output o_byte_ready, o_mem_sel, o_mem_we, o_mem_addr, o_mem_data,
    output o_cpu_enable, o_load_done, o_error, o_state
  );

  // Environment side: UART byte source, instruction memory, CPU.
  modport slave (
    output i_start_load, i_byte, i_byte_valid, i_run, i_step, i_halt,
    input  o_byte_ready, o_mem_sel, o_mem_we, o_mem_addr, o_mem_data,
    input  o_cpu_enable, o_load_done, o_error, o_state
  );
endinterface

// File: rtl/control_carga_instrucciones.sv
// Program loader and CPU run sequencer: packs a byte stream into words written to instruction
// memory until the all-ones HALT word, then gates the CPU in continuous or single-step mode.
module control_carga_instrucciones #(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned CELDAS = 64
) (
  input logic                          i_clk,
  input logic                          i_reset,
  control_carga_instrucciones_if.master bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StWait = 3'd2,
    StRun  = 3'd3,
    StStep = 3'd4,
    StDone = 3'd5
  } state_e;

  localparam logic [NBITS-1:0] LastAddr = NBITS'(CELDAS - 4);
  localparam logic [NBITS-1:0] HaltWord = '1;
  localparam logic [NBITS-1:0] AddrStep = NBITS'(4);

  state_e           state_q, state_d;
  logic [NBITS-1:0] word_q, word_d;
  logic [NBITS-1:0] ptr_q, ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [NBITS-1:0] mem_addr_q, mem_addr_d;
  logic [NBITS-1:0] mem_data_q, mem_data_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_sel_q, mem_sel_d;
  logic             byte_ready_q, byte_ready_d;
  logic             cpu_enable_q, cpu_enable_d;
  logic             load_done_q, load_done_d;
  logic             error_q, error_d;

  logic             byte_acc;
  logic             begin_load;
  logic [NBITS-1:0] word_nxt;

  always_comb begin
    // byte_ready_q is only ever high while in LOAD.
    byte_acc    = bus.i_byte_valid & byte_ready_q;
    word_nxt    = {word_q[NBITS-9:0], bus.i_byte};
    begin_load  = 1'b0;

    state_d     = state_q;
    word_d      = word_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_we_d    = 1'b0;
    load_done_d = 1'b0;
    error_d     = error_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start_load) begin
          begin_load = 1'b1;
        end
      end
      StLoad: begin
        if (byte_acc) begin
          word_d = word_nxt;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            mem_we_d   = 1'b1;
            mem_addr_d = ptr_q;
            mem_data_d = word_nxt;
            ptr_d      = ptr_q + AddrStep;
            if (word_nxt == HaltWord) begin
              state_d     = StWait;
              load_done_d = 1'b1;
            end else if (ptr_q == LastAddr) begin
              state_d = StIdle;
              error_d = 1'b1;
            end
          end
        end
      end
      StWait: begin
        if (bus.i_start_load) begin
          begin_load = 1'b1;
        end else if (bus.i_run) begin
          state_d = StRun;
        end else if (bus.i_step) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (bus.i_halt) begin
          state_d = StDone;
        end
      end
      StStep: begin
        state_d = bus.i_halt ? StDone : StWait;
      end
      StDone: begin
        if (bus.i_start_load) begin
          begin_load = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A (re)load always restarts from address 0 with an empty word.
    if (begin_load) begin
      state_d = StLoad;
      ptr_d   = '0;
      cnt_d   = 2'd0;
      word_d  = '0;
      error_d = 1'b0;
    end

    // Outputs are registered, so they are decoded from the next state.
    byte_ready_d = (state_d == StLoad);
    mem_sel_d    = (state_d == StLoad);
    cpu_enable_d = (state_d == StRun) || (state_d == StStep);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      word_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= 2'd0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
      byte_ready_q <= 1'b0;
      cpu_enable_q <= 1'b0;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      byte_ready_q <= byte_ready_d;
      cpu_enable_q <= cpu_enable_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
    end
  end

  assign bus.o_byte_ready = byte_ready_q;
  assign bus.o_mem_sel    = mem_sel_q;
  assign bus.o_mem_we     = mem_we_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_data   = mem_data_q;
  assign bus.o_cpu_enable = cpu_enable_q;
  assign bus.o_load_done  = load_done_q;
  assign bus.o_error      = error_q;
  assign bus.o_state      = state_q;

endmodule
